// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
//   Bundles the request/grant handshake and address signals between the two
//   bus masters, the arbiter and the address decoder.
//
//   Signals:
//     m1_req, m2_req     master requests (held high for the whole transaction)
//     m1_addr, m2_addr   master addresses
//     m1_grant, m2_grant one-hot bus ownership
//     bus_addr           address handed to the decoder
//     bus_busy           some master owns the bus
//     timeout_err        one-cycle pulse marking a forced release
//
//   Modports:
//     master  the requesting side (drives req/addr, observes grants)
//     slave   the arbiter side (observes req/addr, drives grants and bus)
// ----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              m1_req;
    logic              m2_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [ADDR_W-1:0] m2_addr;
    logic              m1_grant;
    logic              m2_grant;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_busy;
    logic              timeout_err;

    modport master (
        output m1_req, m2_req, m1_addr, m2_addr,
        input  m1_grant, m2_grant, bus_addr, bus_busy, timeout_err
    );

    modport slave (
        input  m1_req, m2_req, m1_addr, m2_addr,
        output m1_grant, m2_grant, bus_addr, bus_busy, timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Two-master round-robin arbiter feeding the system address decoder.
//   Grants one master at a time, drives the owner's address onto bus_addr,
//   inserts one idle handover cycle between owners, and forces a release
//   after TIMEOUT grant cycles when the other master is waiting.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    bus_arbiter_if.slave (requests/addresses in, grants/bus out)
//
//   Parameters:
//     ADDR_W     address width
//     TIMEOUT    max grant cycles while the other master waits (0 = none)
//     IDLE_ADDR  address driven when nobody owns the bus (decodes to nothing)
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int              ADDR_W    = 16,
    parameter int              TIMEOUT   = 64,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 16'hFFFF
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT1   = 2'd1,
        GRANT2   = 2'd2,
        HANDOVER = 2'd3
    } state_t;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } master_t;

    localparam int              CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

    state_t           state;
    master_t          last_grant;
    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_err_q;

    // Single state machine. hold_cnt counts completed grant cycles and
    // saturates, so an uncontested owner may hold the bus indefinitely.
    // A dropped request always wins over the timeout, so a coincident
    // release is reported as a normal one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= M2;
            hold_cnt      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    // On a tie, the master that did not own the bus last wins.
                    if (bus.m1_req && (!bus.m2_req || last_grant == M2)) begin
                        state      <= GRANT1;
                        last_grant <= M1;
                        hold_cnt   <= '0;
                    end else if (bus.m2_req) begin
                        state      <= GRANT2;
                        last_grant <= M2;
                        hold_cnt   <= '0;
                    end
                end
                GRANT1: begin
                    if (!bus.m1_req) begin
                        state <= HANDOVER;
                    end else if (bus.m2_req && TIMEOUT_EN && hold_cnt == CNT_MAX) begin
                        state         <= HANDOVER;
                        timeout_err_q <= 1'b1;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                GRANT2: begin
                    if (!bus.m2_req) begin
                        state <= HANDOVER;
                    end else if (bus.m1_req && TIMEOUT_EN && hold_cnt == CNT_MAX) begin
                        state         <= HANDOVER;
                        timeout_err_q <= 1'b1;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                HANDOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m1_grant    = (state == GRANT1);
    assign bus.m2_grant    = (state == GRANT2);
    assign bus.bus_busy    = (state == GRANT1) || (state == GRANT2);
    assign bus.timeout_err = timeout_err_q;

    // Combinational address pass-through; the decoder registers it.
    always_comb begin
        bus.bus_addr = IDLE_ADDR;
        case (state)
            GRANT1:  bus.bus_addr = bus.m1_addr;
            GRANT2:  bus.bus_addr = bus.m2_addr;
            default: bus.bus_addr = IDLE_ADDR;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed self-checking bench for bus_arbiter (TIMEOUT = 4). Inputs change
//   1 time unit after each rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    localparam logic [15:0] IA = 16'hFFFF;
    localparam logic [15:0] A1 = 16'h0400;
    localparam logic [15:0] A2 = 16'h1800;

    bus_arbiter_if #(.ADDR_W(16)) bif ();

    bus_arbiter #(
        .ADDR_W   (16),
        .TIMEOUT  (4),
        .IDLE_ADDR(16'hFFFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r1, input logic r2,
                                 input logic [15:0] a1, input logic [15:0] a2);
        bif.m1_req  = r1;
        bif.m2_req  = r2;
        bif.m1_addr = a1;
        bif.m2_addr = a2;
    endtask

    // Packs {m1_grant, m2_grant, bus_busy, timeout_err, bus_addr}.
    task automatic checkOutput(input string tag, input logic g1, input logic g2,
                               input logic [15:0] addr, input logic te);
        logic [19:0] obs;
        logic [19:0] exp;
        exp = {g1, g2, (g1 | g2), te, addr};
        obs = {bif.m1_grant, bif.m2_grant, bif.bus_busy, bif.timeout_err, bif.bus_addr};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grants must never both be high.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            total++;
            assert (!(bif.m1_grant === 1'b1 && bif.m2_grant === 1'b1)) else begin
                bad++;
                $error("[TB] FAIL onehot: observed m1_grant=%b m2_grant=%b expected not both 1",
                       bif.m1_grant, bif.m2_grant);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, A1, A2);

        // Asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1 checkOutput("reset_async", 1'b0, 1'b0, IA, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("reset_idle", 1'b0, 1'b0, IA, 1'b0);

        // Single master, 5 grant cycles then release
        $display("[TB] single master");
        applyStimulus(1'b1, 1'b0, A1, A2);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput($sformatf("single_grant_%0d", i), 1'b1, 1'b0, A1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, A1, A2);
        tick();
        checkOutput("single_handover", 1'b0, 1'b0, IA, 1'b0);
        tick();
        checkOutput("single_idle", 1'b0, 1'b0, IA, 1'b0);

        // Tie straight after reset: master 1 first, then master 2
        $display("[TB] tie from reset");
        #3 rst_n = 1'b0;
        #1 checkOutput("reset_again", 1'b0, 1'b0, IA, 1'b0);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, A1, A2);
        tick();
        checkOutput("tie_first_m1", 1'b1, 1'b0, A1, 1'b0);
        applyStimulus(1'b0, 1'b1, A1, A2);
        tick();
        checkOutput("tie_handover", 1'b0, 1'b0, IA, 1'b0);
        applyStimulus(1'b1, 1'b1, A1, A2);
        tick();
        checkOutput("tie_idle", 1'b0, 1'b0, IA, 1'b0);
        tick();
        checkOutput("tie_second_m2", 1'b0, 1'b1, A2, 1'b0);
        applyStimulus(1'b0, 1'b0, A1, A2);
        tick();
        checkOutput("tie_end_handover", 1'b0, 1'b0, IA, 1'b0);
        tick();
        checkOutput("tie_end_idle", 1'b0, 1'b0, IA, 1'b0);

        // Forced release: m1 holds, m2 waits from grant cycle 1
        $display("[TB] timeout");
        applyStimulus(1'b1, 1'b0, A1, A2);
        tick();
        checkOutput("to_grant_1", 1'b1, 1'b0, A1, 1'b0);
        applyStimulus(1'b1, 1'b1, A1, A2);
        for (int i = 2; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("to_grant_%0d", i), 1'b1, 1'b0, A1, 1'b0);
        end
        tick();
        checkOutput("to_handover_err", 1'b0, 1'b0, IA, 1'b1);
        applyStimulus(1'b0, 1'b1, A1, A2);
        tick();
        checkOutput("to_idle_err_clear", 1'b0, 1'b0, IA, 1'b0);
        tick();
        checkOutput("to_m2_grant", 1'b0, 1'b1, A2, 1'b0);

        // Uncontested hold: m2 keeps the bus 20 cycles without a timeout
        $display("[TB] uncontested hold");
        for (int i = 2; i <= 20; i++) begin
            tick();
            checkOutput($sformatf("hold_%0d", i), 1'b0, 1'b1, A2, 1'b0);
        end

        // Reset while m2 owns the bus, then a tie goes to m1
        $display("[TB] reset mid-grant");
        #3 rst_n = 1'b0;
        #1 checkOutput("midgrant_reset", 1'b0, 1'b0, IA, 1'b0);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, A1, A2);
        tick();
        checkOutput("midgrant_tie_m1", 1'b1, 1'b0, A1, 1'b0);

        // Own drop coinciding with the timeout edge is a normal release
        $display("[TB] drop at timeout");
        for (int i = 2; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("drop_grant_%0d", i), 1'b1, 1'b0, A1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, A1, A2);
        tick();
        checkOutput("drop_handover_noerr", 1'b0, 1'b0, IA, 1'b0);
        tick();
        checkOutput("drop_idle", 1'b0, 1'b0, IA, 1'b0);
        tick();
        checkOutput("drop_then_m2", 1'b0, 1'b1, A2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
